// File: rtl/dvi_pixel_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_pixel_serializer_pkg
//  Purpose  : Shared widths, DVI 12-bit dual-edge bit map and pixel stage type.
//  Revision : 1.0  initial release
// ============================================================================
package dvi_pixel_serializer_pkg;

    localparam int c_PIX_W = 24;
    localparam int c_DVI_W = 12;
    localparam logic [c_PIX_W-1:0] c_BORDER_DEFAULT = 24'h000000;

    // Source bit in {R,G,B} for each DVI_D pin, listed pin 0 first
    localparam logic [4:0] c_RISE_SRC [c_DVI_W] = '{
        5'd12, 5'd13, 5'd14, 5'd15, 5'd8, 5'd9, 5'd10, 5'd11,
        5'd20, 5'd21, 5'd22, 5'd23 };
    localparam logic [4:0] c_FALL_SRC [c_DVI_W] = '{
        5'd16, 5'd17, 5'd18, 5'd19, 5'd4, 5'd5, 5'd6, 5'd7,
        5'd0, 5'd1, 5'd2, 5'd3 };

    typedef struct packed {
        logic               de;
        logic               hs;
        logic               vs;
        logic [c_PIX_W-1:0] rgb;
    } dvi_pix_t;

    function automatic logic [c_DVI_W-1:0] dvi_map(input logic [c_PIX_W-1:0] rgb,
                                                   input logic rise);
        logic [c_DVI_W-1:0] lanes;
        lanes = '0;
        for (int i = 0; i < c_DVI_W; i++) begin
            lanes[i] = rise ? rgb[c_RISE_SRC[i]] : rgb[c_FALL_SRC[i]];
        end
        return lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_pixel_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_pixel_serializer_if
//  Purpose  : Valid/ready stream of packed multi-pixel words into the serializer.
//  Revision : 1.0  initial release
// ============================================================================
interface dvi_pixel_serializer_if
    import dvi_pixel_serializer_pkg::*;
#(
    parameter int PIX_PER_WORD = 2
);
    logic [c_PIX_W*PIX_PER_WORD-1:0] in_data;
    logic                            in_valid;
    logic                            in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/dvi_oddr_lane.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_oddr_lane
//  Purpose  : One output DDR pin: d1 while clock is high, d2 while clock is low.
//             Reset/set tied inactive and clock enable tied on.
//  Revision : 1.0  initial release
// ============================================================================
module dvi_oddr_lane (
    input  logic clock,
    input  logic d1,
    input  logic d2,
    output logic q
);
    // d1/d2 come from posedge registers, so d2 is stable before the falling half
    always_comb begin
        q = clock ? d1 : d2;
    end
endmodule
`default_nettype wire

// File: rtl/dvi_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : dvi_pixel_serializer
//  Purpose  : Word FIFO, per-cycle pixel unpack, sync alignment and ODDR pad
//             drive for a 12-bit dual-edge DVI transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module dvi_pixel_serializer
    import dvi_pixel_serializer_pkg::*;
#(
    parameter int                 PIX_PER_WORD = 2,
    parameter int                 FIFO_DEPTH   = 8,
    parameter logic [c_PIX_W-1:0] BORDER_RGB   = c_BORDER_DEFAULT
)(
    input  logic                        clock,
    input  logic                        reset,
    dvi_pixel_serializer_if.slave       pix_in,
    input  logic                        border,
    input  logic                        hs,
    input  logic                        vs,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        DVI_XCLK_P,
    output logic                        DVI_XCLK_N,
    output logic                        DVI_DE,
    output logic                        DVI_H,
    output logic                        DVI_V,
    output logic [c_DVI_W-1:0]          DVI_D
);

    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_IW     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int c_WORD_W = c_PIX_W * PIX_PER_WORD;
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(PIX_PER_WORD - 1);
    localparam logic [c_AW:0]   c_DEPTH_L  = (c_AW + 1)'(FIFO_DEPTH);

    logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic [c_IW-1:0]     r_idx;
    logic                r_vs_prev;
    logic                r_underflow;
    dvi_pix_t            r_pix;

    logic [c_AW:0]        w_level;
    logic                 w_empty;
    logic                 w_active;
    logic                 w_vs_rise;
    logic                 w_pix_ok;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ready;
    logic [c_WORD_W-1:0]  w_head;
    logic [c_PIX_W-1:0]   w_pixel;
    logic [c_DVI_W-1:0]   w_rise;
    logic [c_DVI_W-1:0]   w_fall;

    always_comb begin
        w_level   = r_wr_ptr - r_rd_ptr;
        w_empty   = (w_level == '0);
        w_active  = ~border;
        w_vs_rise = vs & ~r_vs_prev;
        w_pix_ok  = w_active & ~w_empty;
        // Realign keeps the head word so the new frame starts at its pixel 0
        w_pop     = w_pix_ok & ~w_vs_rise & (r_idx == c_IDX_LAST);
        w_ready   = (w_level < c_DEPTH_L) | w_pop;
        w_push    = pix_in.in_valid & w_ready;
        w_head    = r_mem[r_rd_ptr[c_AW-1:0]];
        w_pixel   = w_head[c_PIX_W*int'(r_idx) +: c_PIX_W];
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= pix_in.in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_idx       <= '0;
            r_vs_prev   <= 1'b0;
            r_underflow <= 1'b0;
            r_pix.de    <= 1'b0;
            r_pix.hs    <= 1'b0;
            r_pix.vs    <= 1'b0;
            r_pix.rgb   <= BORDER_RGB;
        end else begin
            r_vs_prev <= vs;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_vs_rise) begin
                r_idx <= '0;
            end else if (w_pix_ok) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_active & w_empty) begin
                r_underflow <= 1'b1;
            end
            r_pix.de  <= w_active;
            r_pix.hs  <= hs;
            r_pix.vs  <= vs;
            r_pix.rgb <= w_pix_ok ? w_pixel : BORDER_RGB;
        end
    end

    assign pix_in.in_ready = w_ready;
    assign fifo_level      = w_level;
    assign underflow       = r_underflow;
    assign w_rise          = dvi_map(r_pix.rgb, 1'b1);
    assign w_fall          = dvi_map(r_pix.rgb, 1'b0);

    dvi_oddr_lane u_xclk_p (.clock(clock), .d1(1'b1),     .d2(1'b0),     .q(DVI_XCLK_P));
    dvi_oddr_lane u_xclk_n (.clock(clock), .d1(1'b0),     .d2(1'b1),     .q(DVI_XCLK_N));
    dvi_oddr_lane u_de     (.clock(clock), .d1(r_pix.de), .d2(r_pix.de), .q(DVI_DE));
    dvi_oddr_lane u_h      (.clock(clock), .d1(r_pix.hs), .d2(r_pix.hs), .q(DVI_H));
    dvi_oddr_lane u_v      (.clock(clock), .d1(r_pix.vs), .d2(r_pix.vs), .q(DVI_V));

    generate
        for (genvar gi = 0; gi < c_DVI_W; gi++) begin : g_data
            dvi_oddr_lane u_d (
                .clock (clock),
                .d1    (w_rise[gi]),
                .d2    (w_fall[gi]),
                .q     (DVI_D[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire
